// File: rtl/sound_pkg.sv
// Shared sound codes, sequencer state encoding and event-priority helpers.
// Also imported by the PWM sound controller.
package sound_pkg;

  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_GO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TONE = 2'b01,
    ST_GAP  = 2'b10
  } seq_state_e;

  // Event vector layout is {goal, paddle, wall}; goal has the highest priority.
  function automatic logic [1:0] event_code(input logic [2:0] ev);
    logic [1:0] code;
    code = SND_STOP;
    if (ev[2]) begin
      code = SND_GO;
    end else if (ev[1]) begin
      code = SND_PING;
    end else if (ev[0]) begin
      code = SND_PONG;
    end else begin
      code = SND_STOP;
    end
    return code;
  endfunction

  function automatic logic multi_event(input logic [2:0] ev);
    return (ev[2] & ev[1]) | (ev[2] & ev[0]) | (ev[1] & ev[0]);
  endfunction

endpackage

// File: rtl/sound_event_fifo.sv
// Small FIFO of pending 2-bit sound codes; DEPTH must be a power of two >= 2.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sound_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] wdata,
  output logic [1:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == {CNT_W{1'b0}});
  assign rdata = mem_q[rd_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (do_push_s) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + PTR_W'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
      wr_q  <= {PTR_W{1'b0}};
      rd_q  <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns one-cycle game-event pulses into timed sound codes followed by a silent gap.
// Optional macro SOUND_SEQ_QUEUE_EN replaces the single pending slot with an arrival-order FIFO.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int TONE_CYCLES = 1_200_000,
  parameter int GAP_CYCLES  = 240_000,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_paddle,
  input  logic       ev_wall,
  input  logic       ev_goal,
  input  logic       mute_in,
  output logic [1:0] code_sound,
  output logic       mute,
  output logic       busy,
  output logic       drop
);

  localparam int MAX_CYC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ev_q, ev_d;
  logic [1:0]       code_q, code_d;
  logic             mute_q, mute_d, busy_q, busy_d, drop_q, drop_d;

  logic             win_valid_s, lose_s, reject_s, pop_s, store_valid_s;
  logic [1:0]       win_code_s, store_code_s;

  assign code_sound = code_q;
  assign mute       = mute_q;
  assign busy       = busy_q;
  assign drop       = drop_q;

  // Resolve the registered event pulses into one winner plus a loser flag.
  always_comb begin
    ev_d        = {ev_goal, ev_paddle, ev_wall};
    win_valid_s = |ev_q;
    win_code_s  = event_code(ev_q);
    lose_s      = multi_event(ev_q);
  end

`ifdef SOUND_SEQ_QUEUE_EN
  logic fifo_full_s, fifo_empty_s, push_s;

  always_comb begin
    pop_s         = (state_q == ST_IDLE) && !fifo_empty_s;
    push_s        = win_valid_s && (!fifo_full_s || pop_s);
    reject_s      = win_valid_s && !push_s;
    store_valid_s = !fifo_empty_s;
  end

  sound_event_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (win_code_s),
    .rdata (store_code_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );
`else
  logic       pend_valid_q, pend_valid_d, accept_s;
  logic [1:0] pend_code_q, pend_code_d;

  // Single pending slot: accept only when the slot is free and nothing is playing.
  always_comb begin
    pop_s         = (state_q == ST_IDLE) && pend_valid_q;
    accept_s      = win_valid_s && !pend_valid_q && (state_q == ST_IDLE);
    reject_s      = win_valid_s && !accept_s;
    store_valid_s = pend_valid_q;
    store_code_s  = pend_code_q;
    if (accept_s) begin
      pend_valid_d = 1'b1;
      pend_code_d  = win_code_s;
    end else if (pop_s) begin
      pend_valid_d = 1'b0;
      pend_code_d  = pend_code_q;
    end else begin
      pend_valid_d = pend_valid_q;
      pend_code_d  = pend_code_q;
    end
  end

  // Pending slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_code_q  <= SND_STOP;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
    end
  end
`endif

  // Tone/gap sequencing and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (store_valid_s) begin
          code_d  = store_code_s;
          cnt_d   = TONE_LOAD;
          state_d = ST_TONE;
        end else begin
          code_d = SND_STOP;
        end
      end
      ST_TONE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          code_d  = SND_STOP;
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        code_d  = SND_STOP;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    mute_d = mute_in || (state_d != ST_TONE);
    drop_d = lose_s || reject_s;
  end

  // State, counter, input-sampling and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ev_q    <= 3'b000;
      code_q  <= SND_STOP;
      mute_q  <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      code_q  <= code_d;
      mute_q  <= mute_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

endmodule
